// File: rtl/upsample_pkg.sv
// Shared defaults, derived widths and the frame-state encoding for upsample_mask.
package upsample_pkg;

  localparam int HRES_DEF        = 1280;
  localparam int VRES_DEF        = 720;
  localparam int KERNEL_SIZE_DEF = 4;

  localparam int HWIDTH_DEF = $clog2(HRES_DEF);
  localparam int VWIDTH_DEF = $clog2(VRES_DEF);
  localparam int KW_DEF     = $clog2(KERNEL_SIZE_DEF);
  localparam int BIN_W_DEF  = HRES_DEF / KERNEL_SIZE_DEF;
  localparam int BIN_H_DEF  = VRES_DEF / KERNEL_SIZE_DEF;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_SHOWING,
    ST_SWAP_PENDING
  } state_t;

endpackage

// File: rtl/xilinx_true_dual_port_read_first_1_clock_ram.sv
// Single-clock true dual-port RAM, read-first on both ports; optional output register.
// Latency 1 (LOW_LATENCY) or 2 (HIGH_PERFORMANCE) cycles; no backpressure.
module xilinx_true_dual_port_read_first_1_clock_ram #(
  parameter int    RAM_WIDTH       = 1,
  parameter int    RAM_DEPTH       = 1024,
  parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE"
) (
  input  logic [$clog2(RAM_DEPTH)-1:0] addra,
  input  logic [$clog2(RAM_DEPTH)-1:0] addrb,
  input  logic [RAM_WIDTH-1:0]         dina,
  input  logic [RAM_WIDTH-1:0]         dinb,
  input  logic                         clka,
  input  logic                         wea,
  input  logic                         web,
  input  logic                         ena,
  input  logic                         enb,
  input  logic                         rsta,
  input  logic                         rstb,
  input  logic                         regcea,
  input  logic                         regceb,
  output logic [RAM_WIDTH-1:0]         douta,
  output logic [RAM_WIDTH-1:0]         doutb
);

  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] ram_a_q;
  logic [RAM_WIDTH-1:0] ram_b_q;

  always_ff @(posedge clka) begin
    if (ena) begin
      if (wea) mem[addra] <= dina;
      ram_a_q <= mem[addra];
    end
    if (enb) begin
      if (web) mem[addrb] <= dinb;
      ram_b_q <= mem[addrb];
    end
  end

  if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_no_reg
    assign douta = ram_a_q;
    assign doutb = ram_b_q;
  end else begin : g_out_reg
    logic [RAM_WIDTH-1:0] douta_q;
    logic [RAM_WIDTH-1:0] doutb_q;

    always_ff @(posedge clka) begin
      if (rsta)        douta_q <= '0;
      else if (regcea) douta_q <= ram_a_q;
      if (rstb)        doutb_q <= '0;
      else if (regceb) doutb_q <= ram_b_q;
    end

    assign douta = douta_q;
    assign doutb = doutb_q;
  end

endmodule

// File: rtl/upsample_mask.sv
// Double-buffered binned mask, nearest-neighbour upsampled to full resolution on request.
// Latency 2 cycles, one request per cycle, never stalls; binned writes dropped while a swap is pending.
module upsample_mask import upsample_pkg::*; #(
  parameter  int HRES        = HRES_DEF,
  parameter  int VRES        = VRES_DEF,
  parameter  int KERNEL_SIZE = KERNEL_SIZE_DEF,
  localparam int HWIDTH      = $clog2(HRES),
  localparam int VWIDTH      = $clog2(VRES),
  localparam int KW          = $clog2(KERNEL_SIZE),
  localparam int BIN_W       = HRES / KERNEL_SIZE,
  localparam int BIN_H       = VRES / KERNEL_SIZE
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [HWIDTH-KW-1:0] bin_hcount_in,
  input  logic [VWIDTH-KW-1:0] bin_vcount_in,
  input  logic                 bin_pixel_in,
  input  logic                 bin_valid_in,
  input  logic [HWIDTH-1:0]    hcount_in,
  input  logic [VWIDTH-1:0]    vcount_in,
  input  logic                 data_valid_in,
  output logic                 pixel_data_out,
  output logic [HWIDTH-1:0]    hcount_out,
  output logic [VWIDTH-1:0]    vcount_out,
  output logic                 data_valid_out,
  output logic                 frame_swap_out,
  output logic                 bin_drop_out
);

  localparam int BHW     = HWIDTH - KW;
  localparam int BVW     = VWIDTH - KW;
  localparam int BIN_PIX = BIN_W * BIN_H;
  localparam int AW      = $clog2(2 * BIN_PIX);

  state_t            state_q, state_d;
  logic              wr_bank_q, wr_bank_d;
  logic              visible_q, visible_d;
  logic              vld1_q, vld1_d, vld2_q, vld2_d;
  logic              show1_q, show1_d, show2_q, show2_d;
  logic [HWIDTH-1:0] h1_q, h1_d, h2_q, h2_d;
  logic [VWIDTH-1:0] v1_q, v1_d, v2_q, v2_d;

  logic          bin_ok, last_wr, req_zero, req_in_range;
  logic          wr_en, swap, rd_bank;
  logic [AW-1:0] wr_addr, rd_addr;
  logic          ram_doutb;
  logic          ram_douta_unused;

  assign bin_ok = bin_valid_in
               && ({1'b0, bin_hcount_in} < (BHW+1)'(BIN_W))
               && ({1'b0, bin_vcount_in} < (BVW+1)'(BIN_H));
  assign last_wr = bin_ok
                && (bin_hcount_in == BHW'(BIN_W - 1))
                && (bin_vcount_in == BVW'(BIN_H - 1));
  assign req_zero = data_valid_in && (hcount_in == '0) && (vcount_in == '0);
  assign req_in_range = ({1'b0, hcount_in} < (HWIDTH+1)'(HRES))
                     && ({1'b0, vcount_in} < (VWIDTH+1)'(VRES));

  always_comb begin
    state_d        = state_q;
    wr_bank_d      = wr_bank_q;
    visible_d      = visible_q;
    wr_en          = 1'b0;
    swap           = 1'b0;
    bin_drop_out   = 1'b0;
    frame_swap_out = 1'b0;
    case (state_q)
      ST_EMPTY, ST_SHOWING: begin
        wr_en = bin_ok;
        if (last_wr) state_d = ST_SWAP_PENDING;
      end
      ST_SWAP_PENDING: begin
        // The completed frame is frozen until it has been handed to the reader.
        bin_drop_out = bin_ok;
        if (req_zero) begin
          swap           = 1'b1;
          frame_swap_out = 1'b1;
          wr_bank_d      = ~wr_bank_q;
          visible_d      = 1'b1;
          state_d        = ST_SHOWING;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Bank 1 occupies the upper half of the RAM; the swap-cycle request already reads the new bank.
  assign rd_bank = swap ? wr_bank_q : ~wr_bank_q;

  always_comb begin
    wr_addr = AW'(bin_vcount_in) * AW'(BIN_W) + AW'(bin_hcount_in)
            + (wr_bank_q ? AW'(BIN_PIX) : '0);
    rd_addr = '0;
    if (req_in_range) begin
      rd_addr = AW'(vcount_in >> KW) * AW'(BIN_W) + AW'(hcount_in >> KW)
              + (rd_bank ? AW'(BIN_PIX) : '0);
    end
  end

  always_comb begin
    vld1_d  = data_valid_in;
    h1_d    = hcount_in;
    v1_d    = vcount_in;
    show1_d = data_valid_in && req_in_range && (visible_q || swap);
    vld2_d  = vld1_q;
    h2_d    = h1_q;
    v2_d    = v1_q;
    show2_d = show1_q;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= ST_EMPTY;
      wr_bank_q <= 1'b0;
      visible_q <= 1'b0;
      vld1_q    <= 1'b0;
      h1_q      <= '0;
      v1_q      <= '0;
      show1_q   <= 1'b0;
      vld2_q    <= 1'b0;
      h2_q      <= '0;
      v2_q      <= '0;
      show2_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_bank_q <= wr_bank_d;
      visible_q <= visible_d;
      vld1_q    <= vld1_d;
      h1_q      <= h1_d;
      v1_q      <= v1_d;
      show1_q   <= show1_d;
      vld2_q    <= vld2_d;
      h2_q      <= h2_d;
      v2_q      <= v2_d;
      show2_q   <= show2_d;
    end
  end

  xilinx_true_dual_port_read_first_1_clock_ram #(
    .RAM_WIDTH       (1),
    .RAM_DEPTH       (2 * BIN_PIX),
    .RAM_PERFORMANCE ("HIGH_PERFORMANCE")
  ) u_ram (
    .addra  (wr_addr),
    .addrb  (rd_addr),
    .dina   (bin_pixel_in),
    .dinb   (1'b0),
    .clka   (clk_in),
    .wea    (wr_en),
    .web    (1'b0),
    .ena    (wr_en),
    .enb    (1'b1),
    .rsta   (1'b0),
    .rstb   (1'b0),
    .regcea (1'b0),
    .regceb (1'b1),
    .douta  (ram_douta_unused),
    .doutb  (ram_doutb)
  );

  // RAM output register has no async reset, so the registered show flag gates it.
  assign pixel_data_out = ram_doutb & show2_q;
  assign data_valid_out = vld2_q;
  assign hcount_out     = h2_q;
  assign vcount_out     = v2_q;

endmodule

// File: tb/tb_upsample_mask.sv
// Randomized bench for upsample_mask against a frame-level reference model (reduced resolution).
module tb_upsample_mask;

  localparam int HRES = 48;
  localparam int VRES = 40;
  localparam int K    = 4;
  localparam int BW   = HRES / K;
  localparam int BH   = VRES / K;
  localparam int HW   = $clog2(HRES);
  localparam int VW   = $clog2(VRES);
  localparam int BHW  = HW - $clog2(K);
  localparam int BVW  = VW - $clog2(K);

  logic           clk_in = 1'b0;
  logic           rst_in;
  logic [BHW-1:0] bin_hcount_in;
  logic [BVW-1:0] bin_vcount_in;
  logic           bin_pixel_in;
  logic           bin_valid_in;
  logic [HW-1:0]  hcount_in;
  logic [VW-1:0]  vcount_in;
  logic           data_valid_in;
  logic           pixel_data_out;
  logic [HW-1:0]  hcount_out;
  logic [VW-1:0]  vcount_out;
  logic           data_valid_out;
  logic           frame_swap_out;
  logic           bin_drop_out;

  always #5 clk_in = ~clk_in;

  upsample_mask #(.HRES(HRES), .VRES(VRES), .KERNEL_SIZE(K)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .bin_hcount_in  (bin_hcount_in),
    .bin_vcount_in  (bin_vcount_in),
    .bin_pixel_in   (bin_pixel_in),
    .bin_valid_in   (bin_valid_in),
    .hcount_in      (hcount_in),
    .vcount_in      (vcount_in),
    .data_valid_in  (data_valid_in),
    .pixel_data_out (pixel_data_out),
    .hcount_out     (hcount_out),
    .vcount_out     (vcount_out),
    .data_valid_out (data_valid_out),
    .frame_swap_out (frame_swap_out),
    .bin_drop_out   (bin_drop_out)
  );

  typedef struct {
    bit vld;
    int h;
    int v;
    bit pix;
    bit chk;
    bit chk_val;
  } exp_t;

  typedef struct {
    int h;
    int v;
    bit p;
  } wr_t;

  // Reference model: two binned frames, which one the writer owns, and whether a frame is on show.
  bit   mdl_bank [2][BW*BH];
  int   mdl_wbank;
  bit   mdl_shown;
  bit   mdl_pending;
  exp_t expq[$];
  wr_t  wq[$];
  bit   cb_mode;
  int   dut_swaps;
  int   dut_drops;
  int   vectors;
  int   miscompares;

  task automatic chk(input string tag, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, got, want, $time);
    end
  endtask

  function automatic exp_t idle_exp();
    exp_t e;
    e.vld = 0; e.h = 0; e.v = 0; e.pix = 0; e.chk = 0; e.chk_val = 0;
    return e;
  endfunction

  task automatic model_reset();
    mdl_wbank   = 0;
    mdl_shown   = 0;
    mdl_pending = 0;
    expq.delete();
    expq.push_back(idle_exp());
  endtask

  // One clock: drive inputs, check the combinational pulses, then the output due this cycle.
  task automatic tick(input bit b_vld, input int b_h, input int b_v, input bit b_pix,
                      input bit r_vld, input int r_h, input int r_v);
    exp_t e;
    bit   ok, last, swap, was_pending;
    bin_valid_in  = b_vld;
    bin_hcount_in = b_h[BHW-1:0];
    bin_vcount_in = b_v[BVW-1:0];
    bin_pixel_in  = b_pix;
    data_valid_in = r_vld;
    hcount_in     = r_h[HW-1:0];
    vcount_in     = r_v[VW-1:0];
    #1;
    ok          = b_vld && (b_h < BW) && (b_v < BH);
    last        = ok && (b_h == BW-1) && (b_v == BH-1);
    was_pending = mdl_pending;
    swap        = was_pending && r_vld && (r_h == 0) && (r_v == 0);
    chk("bin_drop", int'(bin_drop_out), int'(was_pending && ok));
    chk("frame_swap", int'(frame_swap_out), int'(swap));
    dut_swaps += int'(frame_swap_out);
    dut_drops += int'(bin_drop_out);
    if (ok && !was_pending) begin
      mdl_bank[mdl_wbank][b_v*BW + b_h] = b_pix;
      if (last) mdl_pending = 1;
    end
    if (swap) begin
      mdl_wbank   = 1 - mdl_wbank;
      mdl_shown   = 1;
      mdl_pending = 0;
    end
    e = idle_exp();
    e.vld = r_vld;
    e.h   = r_h;
    e.v   = r_v;
    if (r_vld && r_h < HRES && r_v < VRES && mdl_shown)
      e.pix = mdl_bank[1-mdl_wbank][(r_v/K)*BW + r_h/K];
    if (cb_mode && r_vld && r_h == 4 && (r_v == 0 || r_v == 4)) begin
      e.chk     = 1;
      e.chk_val = (r_v == 0);
    end
    expq.push_back(e);
    @(posedge clk_in);
    #1;
    e = expq.pop_front();
    chk("data_valid", int'(data_valid_out), int'(e.vld));
    if (e.vld) begin
      chk("hcount", int'(hcount_out), e.h);
      chk("vcount", int'(vcount_out), e.v);
    end
    chk("pixel", int'(pixel_data_out), int'(e.pix));
    if (e.chk) chk("checker_pixel", int'(pixel_data_out), int'(e.chk_val));
    @(negedge clk_in);
  endtask

  task automatic cyc(input bit use_wq, input bit r_vld, input int r_h, input int r_v);
    wr_t w;
    if (use_wq && wq.size() > 0 && $urandom_range(1) == 1) begin
      w = wq.pop_front();
      tick(1, w.h, w.v, w.p, r_vld, r_h, r_v);
    end else begin
      tick(0, int'($urandom_range(15)), int'($urandom_range(15)), 1'b1, r_vld, r_h, r_v);
    end
  endtask

  task automatic pulse_reset();
    rst_in = 1'b0;
    bin_valid_in  = 0;
    data_valid_in = 0;
    #1;
    chk("rst_valid", int'(data_valid_out), 0);
    chk("rst_pixel", int'(pixel_data_out), 0);
    chk("rst_hcount", int'(hcount_out), 0);
    chk("rst_vcount", int'(vcount_out), 0);
    chk("rst_swap", int'(frame_swap_out), 0);
    chk("rst_drop", int'(bin_drop_out), 0);
    @(negedge clk_in);
    rst_in = 1'b1;
    model_reset();
  endtask

  // Full raster starting at column h0 of row 0, optional random gaps and an optional reset point.
  task automatic raster(input int gap_pct, input bit use_wq, input int rst_at, input int h0);
    int n = 0;
    for (int v = 0; v < VRES; v++) begin
      for (int h = (v == 0) ? h0 : 0; h < HRES; h++) begin
        if (n == rst_at) pulse_reset();
        for (int g = 0; g < 3 && int'($urandom_range(99)) < gap_pct; g++)
          cyc(use_wq, 0, h, v);
        cyc(use_wq, 1, h, v);
        n++;
      end
    end
  endtask

  task automatic fill_frame(input bit random_pix, input bit skip_last, output bit last_pix);
    wr_t w;
    last_pix = 0;
    for (int v = 0; v < BH; v++) begin
      for (int h = 0; h < BW; h++) begin
        w.h = h;
        w.v = v;
        w.p = random_pix ? bit'($urandom_range(1)) : bit'((h ^ v) & 1);
        if (skip_last && h == BW-1 && v == BH-1) last_pix = w.p;
        else wq.push_back(w);
      end
    end
  endtask

  task automatic drain();
    wr_t w;
    for (int i = 0; i < 4*BW*BH && wq.size() > 0; i++) begin
      w = wq.pop_front();
      tick(1, w.h, w.v, w.p, 0, 0, 0);
    end
  endtask

  initial begin
    bit lp;
    int s0, d0;
    wr_t w;
    vectors = 0; miscompares = 0; dut_swaps = 0; dut_drops = 0; cb_mode = 0;
    rst_in = 1'b0;
    bin_valid_in = 0; bin_hcount_in = '0; bin_vcount_in = '0; bin_pixel_in = 0;
    data_valid_in = 0; hcount_in = '0; vcount_in = '0;
    model_reset();
    #2;
    chk("init_valid", int'(data_valid_out), 0);
    chk("init_pixel", int'(pixel_data_out), 0);
    chk("init_swap", int'(frame_swap_out), 0);
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;

    // Nothing completed yet: every pixel dark, no swap.
    s0 = dut_swaps;
    raster(20, 0, -1, 0);
    chk("empty_swaps", dut_swaps - s0, 0);

    // Checkerboard frame, then ten writes while the swap is pending, plus out-of-range writes.
    fill_frame(0, 0, lp);
    drain();
    d0 = dut_drops;
    for (int i = 0; i < 10; i++) begin
      w.h = int'($urandom_range(BW-1));
      w.v = int'($urandom_range(BH-1));
      w.p = bit'($urandom_range(1));
      wq.push_back(w);
    end
    drain();
    tick(1, BW, 0, 1, 0, 0, 0);
    tick(1, 0, BH, 1, 0, 0, 0);
    chk("drop_count", dut_drops - d0, 10);

    s0 = dut_swaps;
    cb_mode = 1;
    raster(10, 0, -1, 0);
    cb_mode = 0;
    chk("cb_swaps", dut_swaps - s0, 1);

    // Out-of-range requests and an out-of-range write while showing.
    d0 = dut_drops;
    tick(1, BW, 0, 1, 1, HRES, 0);
    tick(0, 0, 0, 0, 1, 0, VRES);
    tick(0, 0, 0, 0, 1, (1 << HW) - 1, (1 << VW) - 1);
    tick(0, 0, 0, 0, 0, 0, 0);
    chk("oor_drops", dut_drops - d0, 0);

    // Random frame written during display; last write lands on the (0,0) request.
    fill_frame(1, 1, lp);
    raster(10, 1, -1, 0);
    drain();
    s0 = dut_swaps;
    tick(1, BW-1, BH-1, lp, 1, 0, 0);
    raster(5, 0, -1, 1);
    chk("coincident_swaps", dut_swaps - s0, 0);
    s0 = dut_swaps;
    raster(5, 0, -1, 0);
    chk("deferred_swaps", dut_swaps - s0, 1);

    // Reset mid-raster, then a dark frame, then a fresh frame becomes visible.
    raster(0, 0, HRES*VRES/2 + 7, 0);
    s0 = dut_swaps;
    raster(10, 0, -1, 0);
    chk("post_reset_swaps", dut_swaps - s0, 0);
    fill_frame(1, 0, lp);
    drain();
    s0 = dut_swaps;
    raster(10, 0, -1, 0);
    chk("final_swaps", dut_swaps - s0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/upsample_mask.md
UPSAMPLE_MASK -- requirements
Module: upsample_mask

Interface
REQ-001 SHALL have parameter HRES, default 1280, full-resolution line width in pixels.
REQ-002 SHALL have parameter VRES, default 720, full-resolution frame height in lines.
REQ-003 SHALL have parameter KERNEL_SIZE, default 4, bin edge length; must be a power of 2 dividing HRES and VRES.
REQ-004 SHALL use derived constants HWIDTH=$clog2(HRES), VWIDTH=$clog2(VRES), KW=$clog2(KERNEL_SIZE), BIN_W=HRES/KERNEL_SIZE, BIN_H=VRES/KERNEL_SIZE.
REQ-005 clk_in  input  1  sole clock; all logic on its rising edge.
REQ-006 rst_in  input  1  reset, asynchronous, active-low.
REQ-007 bin_hcount_in  input  HWIDTH-KW  binned column of incoming mask pixel.
REQ-008 bin_vcount_in  input  VWIDTH-KW  binned row of incoming mask pixel.
REQ-009 bin_pixel_in  input  1  binned mask value.
REQ-010 bin_valid_in  input  1  qualifies bin_* inputs for one cycle.
REQ-011 hcount_in  input  HWIDTH  full-resolution column being requested.
REQ-012 vcount_in  input  VWIDTH  full-resolution row being requested.
REQ-013 data_valid_in  input  1  qualifies read request.
REQ-014 pixel_data_out  output  1  upsampled mask pixel.
REQ-015 hcount_out / vcount_out  output  HWIDTH / VWIDTH  request coordinates aligned to pixel_data_out.
REQ-016 data_valid_out  output  1  qualifies outputs.
REQ-017 frame_swap_out  output  1  one-cycle pulse when a completed binned frame becomes visible.
REQ-018 bin_drop_out  output  1  one-cycle pulse when a binned write is discarded.

Function
REQ-019 SHALL hold two banks of BIN_W*BIN_H bits; write bank and read bank always differ.
REQ-020 Valid binned write SHALL store bin_pixel_in at address bin_vcount_in*BIN_W+bin_hcount_in in write bank, one cycle.
REQ-021 Binned write with bin_hcount_in>=BIN_W or bin_vcount_in>=BIN_H SHALL be ignored without bin_drop_out.
REQ-022 Read request SHALL fetch read-bank address (vcount_in>>KW)*BIN_W+(hcount_in>>KW); each binned pixel replicates over a KERNEL_SIZE x KERNEL_SIZE block.
REQ-023 Latency SHALL be exactly 2 cycles: data_valid_out, hcount_out, vcount_out, pixel_data_out equal request values delayed 2 cycles; no stalls, back-to-back requests every cycle.
REQ-024 Out-of-range request (hcount_in>=HRES or vcount_in>=VRES) SHALL pass valid/coords with pixel_data_out=0.
REQ-025 FSM states: EMPTY (no frame completed), SHOWING, SWAP_PENDING.
REQ-026 EMPTY: pixel_data_out=0 for all requests; write of (BIN_W-1,BIN_H-1) -> SWAP_PENDING.
REQ-027 SHOWING: write of (BIN_W-1,BIN_H-1) -> SWAP_PENDING.
REQ-028 SWAP_PENDING: first valid request with hcount_in=0, vcount_in=0 in a strictly later cycle toggles banks, pulses frame_swap_out same cycle, -> SHOWING; that request reads the new bank.
REQ-029 SWAP_PENDING: all binned writes SHALL be dropped, each pulsing bin_drop_out, protecting the completed frame.
REQ-030 Last-pixel write and (0,0) request in same cycle: swap deferred to next (0,0) request.
REQ-031 Frame completion judged only by last-address write; out-of-order or partial frames are accepted as written.

Reset
REQ-032 rst_in low SHALL asynchronously force EMPTY, write bank 0, read bank 1, all outputs 0, pipeline valids 0.
REQ-033 Reset mid-frame SHALL discard partial frame; RAM contents not cleared, masked by EMPTY until next completion.

Structure
REQ-034 Package upsample_pkg SHALL hold default HRES/VRES/KERNEL_SIZE, derived width constants, FSM state enum.
REQ-035 Storage SHALL be one xilinx_true_dual_port_read_first_1_clock_ram, depth 2*BIN_W*BIN_H, HIGH_PERFORMANCE, bank select as address MSB; port A write, port B read.
REQ-036 Address multiplies by constant BIN_W only; no general multipliers.

Verification
REQ-037 Reset, then raster requests over full frame -> data_valid_out follows 2 cycles later, pixel_data_out all 0, no frame_swap_out.
REQ-038 Write binned checkerboard (bin_pixel=(bh^bv)&1) full 320x180, then raster -> frame_swap_out at (0,0), pixel at (h,v)=((h>>2)^(v>>2))&1, e.g. (4,0)=1, (4,4)=0.
REQ-039 During SWAP_PENDING issue 10 binned writes -> 10 bin_drop_out pulses, displayed frame unchanged.
REQ-040 Last binned write coincident with (0,0) request -> no swap that frame; swap at following (0,0).
REQ-041 Requests at (1280,0) and (0,720) -> valid passed, pixel 0; binned write at (320,0) ignored, no drop pulse.
REQ-042 Assert rst_in low mid-raster for 1 cycle -> outputs 0 immediately, state EMPTY, next frame outputs 0 until new completion.
